// File: rtl/stacker_pkg.sv
// Shared types and default parameters for the stacker game engine.
// Optional build macro: STACKER_SPEEDUP_EN (the move period shrinks as the stack grows).
package stacker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_DROP,
    S_WON,
    S_LOST
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HEIGHT      = 8;
  localparam int DEF_INIT_BLOCKS = 3;
  localparam int DEF_TICK_DIV    = 4;

endpackage

// File: rtl/stacker_tick_gen.sv
// Period counter. It produces a one-cycle tick every 'period' clocks.
// While clr is high, the counter stays at zero and no tick is produced.
module stacker_tick_gen
  import stacker_pkg::*;
#(
  parameter int PER_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] cnt_d;

  // Tick on the last count of the period, then wrap to zero.
  always_comb begin
    tick = !clr && (cnt_q >= (period - 1'b1));
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stacker_engine.sv
// Stacker arcade game engine. A lit block bounces across the current row.
// A go pulse drops the block onto the row below, and the block keeps only
// the cells that overlap the row below. The game is won when the top row is
// reached and lost when the overlap is empty.
// Optional build macro: STACKER_SPEEDUP_EN. When defined, the move period is
// max(1, TICK_DIV - cur_row) instead of TICK_DIV.
module stacker_engine
  import stacker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int INIT_BLOCKS = DEF_INIT_BLOCKS,
  parameter int TICK_DIV    = DEF_TICK_DIV
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        go,
  output logic [HEIGHT*WIDTH-1:0]     rows,
  output logic [$clog2(HEIGHT)-1:0]   cur_row,
  output logic                        busy,
  output logic                        won,
  output logic                        lost
);

  localparam int                RW        = $clog2(HEIGHT);
  localparam int                PER_W     = $clog2(TICK_DIV + 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [WIDTH-1:0]  INIT_MASK = WIDTH'((64'd1 << INIT_BLOCKS) - 64'd1);

  state_e                   state_q;
  logic [HEIGHT*WIDTH-1:0]  rows_q;
  logic [RW-1:0]            cur_row_q;
  logic [WIDTH-1:0]         prev_q;
  logic [WIDTH-1:0]         blk_q;
  logic                     dir_left_q;
  logic                     busy_q;
  logic                     won_q;
  logic                     lost_q;

  logic                     tick;
  logic                     tick_clr;
  logic [PER_W-1:0]         period;
  logic [WIDTH-1:0]         cur_bits;
  logic [WIDTH-1:0]         mv_d;
  logic [WIDTH-1:0]         new_d;
  logic                     dir_left_d;

`ifdef STACKER_SPEEDUP_EN
  // Higher rows move faster, but the period never drops below one clock.
  always_comb begin
    if (int'(cur_row_q) >= TICK_DIV - 1) begin
      period = PER_W'(1);
    end else begin
      period = PER_W'(TICK_DIV - int'(cur_row_q));
    end
  end
`else
  assign period = PER_W'(TICK_DIV);
`endif

  // The counter runs only while a row is moving, so each new row starts a fresh period.
  assign tick_clr = (state_q != S_MOVE);

  stacker_tick_gen #(
    .PER_W (PER_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (tick_clr),
    .period (period),
    .tick   (tick)
  );

  // Bounce the moving row off the edges and compute the overlap with the row below.
  always_comb begin
    cur_bits   = rows_q[cur_row_q*WIDTH +: WIDTH];
    dir_left_d = dir_left_q;
    mv_d       = cur_bits;
    if (dir_left_q) begin
      if (cur_bits[WIDTH-1]) begin
        dir_left_d = 1'b0;
        mv_d       = cur_bits >> 1;
      end else begin
        mv_d       = cur_bits << 1;
      end
    end else begin
      if (cur_bits[0]) begin
        dir_left_d = 1'b1;
        mv_d       = cur_bits << 1;
      end else begin
        mv_d       = cur_bits >> 1;
      end
    end
    new_d = cur_bits & prev_q;
  end

  // Game FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cur_row_q  <= '0;
      prev_q     <= '1;
      blk_q      <= '0;
      dir_left_q <= 1'b1;
      busy_q     <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            state_q    <= S_LOAD;
            rows_q     <= '0;
            cur_row_q  <= '0;
            prev_q     <= '1;
            blk_q      <= INIT_MASK;
            dir_left_q <= 1'b1;
            busy_q     <= 1'b1;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          rows_q[cur_row_q*WIDTH +: WIDTH] <= blk_q;
          state_q                          <= S_MOVE;
        end
        S_MOVE: begin
          // go wins over a coincident tick, so the drop uses the position the player saw.
          if (go) begin
            state_q <= S_DROP;
          end else if (tick) begin
            rows_q[cur_row_q*WIDTH +: WIDTH] <= mv_d;
            dir_left_q                       <= dir_left_d;
          end
        end
        S_DROP: begin
          rows_q[cur_row_q*WIDTH +: WIDTH] <= new_d;
          if (new_d == '0) begin
            state_q <= S_LOST;
            busy_q  <= 1'b0;
            lost_q  <= 1'b1;
          end else if (cur_row_q == LAST_ROW) begin
            state_q <= S_WON;
            busy_q  <= 1'b0;
            won_q   <= 1'b1;
          end else begin
            prev_q     <= new_d;
            blk_q      <= new_d;
            cur_row_q  <= cur_row_q + 1'b1;
            dir_left_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rows    = rows_q;
  assign cur_row = cur_row_q;
  assign busy    = busy_q;
  assign won     = won_q;
  assign lost    = lost_q;

endmodule

// File: tb/tb_stacker_engine.sv
// Directed bench for stacker_engine (WIDTH=8, HEIGHT=8, INIT_BLOCKS=3, TICK_DIV=4).
// Expected row values are queued when a step is driven and popped when the row is observed.
module tb_stacker_engine;

  localparam int W = 8;
  localparam int H = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           go;
  logic [H*W-1:0] rows;
  logic [2:0]     cur_row;
  logic           busy;
  logic           won;
  logic           lost;

  int             total  = 0;
  int             passed = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   m_prev;

  stacker_engine #(
    .WIDTH       (8),
    .HEIGHT      (8),
    .INIT_BLOCKS (3),
    .TICK_DIV    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .go      (go),
    .rows    (rows),
    .cur_row (cur_row),
    .busy    (busy),
    .won     (won),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row_of(input int r);
    return rows[r*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    total++;
    assert (exp_q.size() != 0) else begin
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (obs === e) begin
        passed++;
      end else begin
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first MOVE cycle of row 0 (block loaded, period counter at zero).
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  // Returns on the cycle after DROP (LOAD of the next row, or WON/LOST).
  task automatic drop();
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(1);
  endtask

  initial begin
    logic [7:0] seq [7];
    seq[0] = 8'h07; seq[1] = 8'h0E; seq[2] = 8'h1C; seq[3] = 8'h38;
    seq[4] = 8'h70; seq[5] = 8'hE0; seq[6] = 8'h70;

    reset = 1'b1;
    start = 1'b0;
    go    = 1'b0;
    step(3);
    chk("reset_rows", rows, 64'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_won", won, 1'b0);
    chk("reset_lost", lost, 1'b0);
    chk("reset_cur_row", cur_row, 3'd0);
    reset = 1'b0;
    step(2);

    // go while idle does nothing
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(2);
    chk("idle_go_rows", rows, 64'h0);
    chk("idle_go_busy", busy, 1'b0);

    // free-running bounce on row 0
    pulse_start();
    for (int i = 0; i < 7; i++) exp_q.push_back(seq[i]);
    chk("move_busy", busy, 1'b1);
    chk_sb("bounce_0", row_of(0));
    for (int i = 1; i < 7; i++) begin
      step(4);
      chk_sb($sformatf("bounce_%0d", i), row_of(0));
    end
    // start during MOVE is ignored
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_in_move_row0", row_of(0), 8'h70);
    chk("start_in_move_busy", busy, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);

    // go coincides with a tick at 0x0E: the pre-tick position is dropped
    pulse_start();
    m_prev = 8'hFF;
    step(7);
    chk("pretick_pos", row_of(0), 8'h0E);
    exp_q.push_back(8'h0E & m_prev);
    drop();
    chk_sb("tick_go_row0", row_of(0));
    chk("tick_go_cur_row", cur_row, 3'd1);
    exp_q.push_back(8'h0E);
    step(1);
    chk_sb("tick_go_row1_load", row_of(1));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);

    // trimming: drop 0x07 then 0x0E
    pulse_start();
    m_prev = 8'hFF;
    exp_q.push_back(8'h07 & m_prev);
    drop();
    chk_sb("trim_row0", row_of(0));
    m_prev = 8'h07;
    step(1);
    step(4);
    exp_q.push_back(8'h0E & m_prev);
    drop();
    chk_sb("trim_row1", row_of(1));
    chk("trim_cur_row", cur_row, 3'd2);
    m_prev = 8'h06;
    exp_q.push_back(m_prev);
    step(1);
    chk_sb("trim_row2_load", row_of(2));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);

    // miss: drop 0x07 then 0x38 -> lost
    pulse_start();
    m_prev = 8'hFF;
    exp_q.push_back(8'h07 & m_prev);
    drop();
    chk_sb("miss_row0", row_of(0));
    m_prev = 8'h07;
    step(1);
    step(12);
    chk("miss_pos", row_of(1), 8'h38);
    exp_q.push_back(8'h38 & m_prev);
    drop();
    chk_sb("miss_row1", row_of(1));
    chk("miss_lost", lost, 1'b1);
    chk("miss_busy", busy, 1'b0);
    chk("miss_won", won, 1'b0);
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(3);
    chk("lost_go_rows", rows, 64'h0000_0000_0000_0007);
    chk("lost_go_lost", lost, 1'b1);

    // restart from LOST, then drop every row immediately -> won
    pulse_start();
    chk("restart_lost_clear", lost, 1'b0);
    chk("restart_rows", rows, 64'h0000_0000_0000_0007);
    for (int r = 0; r < H; r++) begin
      exp_q.push_back(8'h07);
      drop();
      chk_sb($sformatf("win_row%0d", r), row_of(r));
      if (r < H - 1) step(1);
    end
    chk("win_rows", rows, 64'h0707_0707_0707_0707);
    chk("win_won", won, 1'b1);
    chk("win_busy", busy, 1'b0);
    chk("win_lost", lost, 1'b0);
    chk("win_cur_row", cur_row, 3'd7);
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(5);
    chk("win_frozen", rows, 64'h0707_0707_0707_0707);
    chk("win_held", won, 1'b1);

    // restart from WON
    pulse_start();
    chk("restart_won_clear", won, 1'b0);
    chk("restart_won_rows", rows, 64'h0000_0000_0000_0007);

    // reset mid-game on row 4
    for (int r = 0; r < 4; r++) begin
      drop();
      step(1);
    end
    chk("abort_cur_row_pre", cur_row, 3'd4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_rows", rows, 64'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_won", won, 1'b0);
    chk("abort_lost", lost, 1'b0);
    chk("abort_cur_row", cur_row, 3'd0);
    step(2);
    chk("abort_idle_rows", rows, 64'h0);
    pulse_start();
    chk("abort_restart_row0", row_of(0), 8'h07);
    chk("abort_restart_cur_row", cur_row, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stacker_engine.md
STACKER_ENGINE -- requirements
Module: stacker_engine

Parameters
REQ-001 WIDTH, 8: columns per row; legal range 4..32.
REQ-002 HEIGHT, 8: number of rows; legal range 2..32.
REQ-003 INIT_BLOCKS, 3: lit cells in the first moving row; legal range 1..WIDTH-1.
REQ-004 TICK_DIV, 4: clocks per one-cell move; minimum 1.

Interface
REQ-005 clk  in  1: sole clock; all state updates on its rising edge.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 start  in  1: one-cycle pulse; starts a game from IDLE, WON or LOST.
REQ-008 go  in  1: one-cycle pulse; drops the moving row.
REQ-009 rows  out  HEIGHT*WIDTH: board image; row r occupies bits [r*WIDTH +: WIDTH].
REQ-010 cur_row  out  $clog2(HEIGHT): index of the row now moving.
REQ-011 busy  out  1: high in LOAD, MOVE and DROP.
REQ-012 won  out  1 / lost  out  1: level outputs, held until the next start or reset.

Function
REQ-013 FSM states: IDLE, LOAD, MOVE, DROP, WON, LOST.
REQ-014 IDLE, WON or LOST plus start -> LOAD: clear all rows, cur_row=0, prev=all-ones, blk={INIT_BLOCKS ones at LSBs}, dir=left.
REQ-015 LOAD -> MOVE after 1 cycle: rows[cur_row]=blk, tick counter cleared.
REQ-016 In MOVE, one tick every TICK_DIV clocks moves the row one cell.
REQ-017 Moving left: if bit WIDTH-1 is set, dir becomes right and the row shifts right on the same tick; otherwise the row shifts left.
REQ-018 Moving right: the mirror of REQ-017, using bit 0.
REQ-019 MOVE plus go -> DROP; a tick in the same cycle as go is discarded, so the drop uses the pre-tick position.
REQ-020 DROP takes 1 cycle: new = rows[cur_row] & prev, and rows[cur_row] = new.
REQ-021 In DROP, if new == 0 the next state is LOST.
REQ-022 In DROP, else if cur_row == HEIGHT-1 the next state is WON.
REQ-023 In DROP, otherwise prev=new, blk=new, cur_row++, dir=left, and the next state is LOAD.
REQ-024 The trimmed block keeps its trimmed width and position into the next row.
REQ-025 go outside MOVE is ignored; start in LOAD, MOVE or DROP is ignored.
REQ-026 won=1 only in WON and lost=1 only in LOST; the rows image freezes in both states.

Reset
REQ-027 While reset is high: state=IDLE, rows=0, cur_row=0, busy=0, won=0, lost=0, tick counter=0, dir=left.
REQ-028 Reset mid-game aborts immediately; the first cycle after reset is IDLE with no residue.

Configuration
REQ-029 Macro STACKER_SPEEDUP_EN enables speedup.
REQ-030 With STACKER_SPEEDUP_EN defined, move period = max(1, TICK_DIV - cur_row).
REQ-031 Without STACKER_SPEEDUP_EN, move period = TICK_DIV for every row.

Structure
REQ-032 Package stacker_pkg holds the state enum type and the default WIDTH, HEIGHT, INIT_BLOCKS and TICK_DIV constants.
REQ-033 Sub-module stacker_tick_gen provides the period counter: inputs clr and period, output one-cycle tick.

Verification (WIDTH=8, HEIGHT=8, INIT_BLOCKS=3, TICK_DIV=4, macro off)
REQ-034 Start with go held low -> row0 reads 0x07, 0x0E, 0x1C, ... 0xE0, then 0x70; each step is 4 clocks apart.
REQ-035 Start, then go before any tick on each of the 8 rows -> every row reads 0x07, won=1, busy=0.
REQ-036 Drop row0 at 0x07, then drop row1 at 0x0E -> row1 reads 0x06, and row2 loads 0x06.
REQ-037 Drop row0 at 0x07, then drop row1 at 0x38 -> row1 reads 0x00, lost=1, and later go pulses have no effect.
REQ-038 Pulse reset in MOVE on row 4 -> next cycle rows=0, state IDLE, won=0, lost=0; a following start gives row0=0x07.
REQ-039 go in the same cycle as a tick at 0x0E -> rows[cur_row]=0x0E after DROP, not 0x1C.
